// File: rtl/regf_sb.sv
// Multi-port integer register file with a per-register busy scoreboard.
// x0 is hardwired to zero; optional same-cycle write-to-read forwarding.
module regf_sb #(
    parameter int WIDTH  = 32,
    parameter int AW     = 4,
    parameter int NRD    = 2,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NRD*AW-1:0]       i_raddr,
    output logic [NRD*WIDTH-1:0]    o_rdata,
    output logic [NRD-1:0]          o_rbusy,
    input  logic                    i_iss_en,
    input  logic [AW-1:0]           i_iss_addr,
    input  logic [NWR-1:0]          i_wen,
    input  logic [NWR*AW-1:0]       i_waddr,
    input  logic [NWR*WIDTH-1:0]    i_wdata,
    output logic [(2**AW)-1:0]      o_busy_vec,
    output logic                    o_a0zero
`ifdef SIMULATION
    ,
    output logic [(2**AW)*WIDTH-1:0] o_flat_rf
`endif
);

    // x10 (a0) must exist, so AW must be at least 4.
    localparam int NREG = 2**AW;

    logic [WIDTH-1:0] rf [NREG];
    logic [NREG-1:0]  busy;
    logic [NREG-1:0]  busy_nxt;

    // Later write ports overwrite earlier ones, giving highest-index priority.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int r = 0; r < NREG; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (i_wen[j] && (i_waddr[j*AW +: AW] != '0)) begin
                    rf[i_waddr[j*AW +: AW]] <= i_wdata[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Issue is applied after writeback so a same-cycle set beats the clear.
    always_comb begin
        busy_nxt = busy;
        for (int j = 0; j < NWR; j++) begin
            if (i_wen[j]) begin
                busy_nxt[i_waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (i_iss_en) begin
            busy_nxt[i_iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] d;
        logic             hit;
        o_rdata = '0;
        o_rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            ra  = i_raddr[k*AW +: AW];
            d   = rf[ra];
            hit = 1'b0;
            if (BYPASS != 0) begin
                for (int j = 0; j < NWR; j++) begin
                    if (i_wen[j] && (i_waddr[j*AW +: AW] == ra)) begin
                        hit = 1'b1;
                        d   = i_wdata[j*WIDTH +: WIDTH];
                    end
                end
            end
            if (ra == '0) begin
                hit = 1'b0;
                d   = '0;
            end
            o_rdata[k*WIDTH +: WIDTH] = d;
            o_rbusy[k]                = busy[ra] & ~hit;
        end
    end

    assign o_busy_vec = busy;
    assign o_a0zero   = ~|rf[10];

`ifdef SIMULATION
    always_comb begin
        o_flat_rf = '0;
        for (int r = 0; r < NREG; r++) begin
            o_flat_rf[r*WIDTH +: WIDTH] = rf[r];
        end
    end
`endif

endmodule

// File: tb/tb_regf_sb.sv
// Directed bench for regf_sb: one forwarding and one non-forwarding instance
// share stimulus; expectations are queued and then drained against outputs.
module tb_regf_sb;

    localparam int WIDTH = 32;
    localparam int AW    = 4;
    localparam int NREG  = 16;

    localparam int K_RD0  = 0;
    localparam int K_RD1  = 1;
    localparam int K_RB   = 2;
    localparam int K_BV   = 3;
    localparam int K_AZ   = 4;
    localparam int K_NRD0 = 5;
    localparam int K_NRD1 = 6;
    localparam int K_NRB  = 7;
    localparam int K_NBV  = 8;
    localparam int K_NAZ  = 9;

    logic                clk = 1'b0;
    logic                rst;
    logic [2*AW-1:0]     raddr;
    logic [2*WIDTH-1:0]  rdata_b, rdata_n;
    logic [1:0]          rbusy_b, rbusy_n;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [1:0]          wen;
    logic [2*AW-1:0]     waddr;
    logic [2*WIDTH-1:0]  wdata;
    logic [NREG-1:0]     bv_b, bv_n;
    logic                az_b, az_n;
`ifdef SIMULATION
    logic [NREG*WIDTH-1:0] flat_b, flat_n;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int          kind_q[$];
    logic [31:0] val_q[$];
    string       tag_q[$];

    regf_sb #(.WIDTH(WIDTH), .AW(AW), .NRD(2), .NWR(2), .BYPASS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_b),
        .o_rbusy(rbusy_b), .i_iss_en(iss_en), .i_iss_addr(iss_addr),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .o_busy_vec(bv_b), .o_a0zero(az_b)
`ifdef SIMULATION
        , .o_flat_rf(flat_b)
`endif
    );

    regf_sb #(.WIDTH(WIDTH), .AW(AW), .NRD(2), .NWR(2), .BYPASS(0)) dnb (
        .i_clk(clk), .i_rst(rst), .i_raddr(raddr), .o_rdata(rdata_n),
        .o_rbusy(rbusy_n), .i_iss_en(iss_en), .i_iss_addr(iss_addr),
        .i_wen(wen), .i_waddr(waddr), .i_wdata(wdata),
        .o_busy_vec(bv_n), .o_a0zero(az_n)
`ifdef SIMULATION
        , .o_flat_rf(flat_n)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_RD0:   return rdata_b[31:0];
            K_RD1:   return rdata_b[63:32];
            K_RB:    return {30'd0, rbusy_b};
            K_BV:    return {16'd0, bv_b};
            K_AZ:    return {31'd0, az_b};
            K_NRD0:  return rdata_n[31:0];
            K_NRD1:  return rdata_n[63:32];
            K_NRB:   return {30'd0, rbusy_n};
            K_NBV:   return {16'd0, bv_n};
            K_NAZ:   return {31'd0, az_n};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_val(input int kind, input logic [31:0] v, input string tag);
        kind_q.push_back(kind);
        val_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check_all();
        while (kind_q.size() > 0) begin
            int          k;
            logic [31:0] v;
            logic [31:0] obs;
            string       t;
            k   = kind_q.pop_front();
            v   = val_q.pop_front();
            t   = tag_q.pop_front();
            obs = observe(k);
            n_checks++;
            assert (obs === v) n_pass++;
            else $error("FAIL %s: observed 0x%0h expected 0x%0h", t, obs, v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int j, input logic [AW-1:0] a, input logic [31:0] d);
        wen[j]               = 1'b1;
        waddr[j*AW +: AW]    = a;
        wdata[j*WIDTH +: WIDTH] = d;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic idle();
        wen      = '0;
        waddr    = '0;
        wdata    = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        set_rd(4'd5, 4'd6);
        #1;
        expect_val(K_BV,   32'h0, "reset_busy_vec");
        expect_val(K_AZ,   32'h1, "reset_a0zero");
        expect_val(K_RB,   32'h0, "reset_rbusy");
        expect_val(K_RD0,  32'h0, "reset_rdata0");
        expect_val(K_NRD1, 32'h0, "reset_rdata1_nb");
        check_all();
        tick();
        rst = 1'b0;

        // Write x5, issue x6, then reset asynchronously mid-cycle.
        tick();
        set_wr(0, 4'd5, 32'h1234);
        iss_en = 1'b1; iss_addr = 4'd6;
        tick();
        idle();
        #1;
        expect_val(K_NRD0, 32'h1234, "pre_reset_x5");
        expect_val(K_NBV,  32'h0040, "pre_reset_busy_x6");
        expect_val(K_NRB,  32'h2,    "pre_reset_rbusy_x6");
        check_all();
        #2;
        rst = 1'b1;
        set_wr(0, 4'd5, 32'h9999);
        iss_en = 1'b1; iss_addr = 4'd5;
        #1;
        expect_val(K_NRD0, 32'h0,    "async_reset_x5");
        expect_val(K_RD0,  32'h9999, "reset_live_bypass_x5");
        expect_val(K_BV,   32'h0,    "async_reset_busy_vec");
        expect_val(K_NAZ,  32'h1,    "async_reset_a0zero");
        check_all();
        tick();
        idle();
        #1;
        expect_val(K_RD0, 32'h0, "write_during_reset_discarded");
        expect_val(K_BV,  32'h0, "issue_during_reset_discarded");
        check_all();
        rst = 1'b0;
        tick();

        // Both write ports target x3: port 1 wins.
        set_rd(4'd3, 4'd0);
        set_wr(0, 4'd3, 32'hAAAA_0000);
        set_wr(1, 4'd3, 32'h5555_FFFF);
        #1;
        expect_val(K_RD0,  32'h5555_FFFF, "prio_bypass_x3");
        expect_val(K_NRD0, 32'h0,         "prio_nobypass_stored_x3");
        check_all();
        tick();
        idle();
        #1;
        expect_val(K_RD0,  32'h5555_FFFF, "prio_stored_x3");
        expect_val(K_NRD0, 32'h5555_FFFF, "prio_stored_x3_nb");
        expect_val(K_BV,   32'h0,         "nonbusy_write_busy_stays_0");
        check_all();

        // x0 writes and issues are ignored.
        set_rd(4'd0, 4'd0);
        set_wr(0, 4'd0, 32'hDEAD_BEEF);
        iss_en = 1'b1; iss_addr = 4'd0;
        #1;
        expect_val(K_RD0, 32'h0, "x0_no_bypass");
        expect_val(K_RB,  32'h0, "x0_rbusy_live");
        check_all();
        tick();
        idle();
        #1;
        expect_val(K_RD0, 32'h0, "x0_read");
        expect_val(K_RB,  32'h0, "x0_rbusy");
        expect_val(K_BV,  32'h0, "x0_busy_vec");
        check_all();

        // Scoreboard lifecycle on x7 read by port 1.
        set_rd(4'd3, 4'd7);
        iss_en = 1'b1; iss_addr = 4'd7;
        tick();
        idle();
        #1;
        expect_val(K_BV,  32'h0080, "issue_x7_busy");
        expect_val(K_RB,  32'h2,    "issue_x7_rbusy1");
        expect_val(K_NRB, 32'h2,    "issue_x7_rbusy1_nb");
        check_all();
        tick();
        tick();
        tick();
        set_wr(0, 4'd7, 32'h42);
        #1;
        expect_val(K_RB,   32'h0,  "wb_x7_bypass_rbusy");
        expect_val(K_RD1,  32'h42, "wb_x7_bypass_rdata");
        expect_val(K_NRB,  32'h2,  "wb_x7_nobypass_rbusy");
        expect_val(K_NRD1, 32'h0,  "wb_x7_nobypass_rdata");
        expect_val(K_BV,   32'h0080, "wb_x7_busy_still_set");
        check_all();
        tick();
        idle();
        #1;
        expect_val(K_BV,   32'h0,  "wb_x7_busy_cleared");
        expect_val(K_NRB,  32'h0,  "wb_x7_rbusy_cleared_nb");
        expect_val(K_NRD1, 32'h42, "wb_x7_stored_nb");
        check_all();

        // Same-cycle writeback and issue on x9: the set wins.
        set_rd(4'd9, 4'd7);
        iss_en = 1'b1; iss_addr = 4'd9;
        tick();
        idle();
        set_wr(1, 4'd9, 32'h99);
        iss_en = 1'b1; iss_addr = 4'd9;
        tick();
        idle();
        #1;
        expect_val(K_BV,   32'h0200, "collision_busy_x9");
        expect_val(K_NRD0, 32'h99,   "collision_data_x9");
        expect_val(K_RB,   32'h1,    "collision_rbusy_x9");
        check_all();
        set_wr(0, 4'd9, 32'h100);
        tick();
        idle();
        #1;
        expect_val(K_BV, 32'h0, "x9_final_clear");
        check_all();

        // a0zero tracks the stored x10 only.
        set_rd(4'd10, 4'd0);
        set_wr(0, 4'd10, 32'h1);
        #1;
        expect_val(K_AZ,  32'h1, "a0zero_ignores_bypass_set");
        expect_val(K_RD0, 32'h1, "a0_bypass_rdata");
        check_all();
        tick();
        idle();
        #1;
        expect_val(K_AZ,  32'h0, "a0zero_cleared");
        expect_val(K_NAZ, 32'h0, "a0zero_cleared_nb");
        check_all();
        set_wr(1, 4'd10, 32'h0);
        #1;
        expect_val(K_AZ, 32'h0, "a0zero_ignores_bypass_zero");
        check_all();
        tick();
        idle();
        #1;
        expect_val(K_AZ, 32'h1, "a0zero_set_again");
        check_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
